// File: rtl/cluster_unpacker.sv
// cluster_unpacker: rebuilds the S-bit strip map of one bunch crossing from
// its packed clusters and re-serializes it as 16-bit words per VFAT over the
// four clock4x phases (the same 4-phase format the packer front end eats).
//
// Ports:
//   clock4x        4x LHC clock
//   reset_n        async active-low reset
//   clusters_in    NUM_CLUSTERS x 14 b, cluster i at [14i+13:14i]
//                  ([10:0] first strip, [13:11] extra adjacent strips)
//   cluster_strobe clusters_in valid, accepted in phase 0 only
//   vfat_words     VFAT v word at [16v+15:16v]
//   frame_sync     high with word 0 of a frame
//   cluster_count  valid clusters in the frame being transmitted
//   strobe_err     one-cycle pulse after a strobe outside phase 0
module cluster_unpacker #(
  parameter int NUM_VFATS    = 24,
  parameter int NUM_CLUSTERS = 8
) (
  input  logic                          clock4x,
  input  logic                          reset_n,
  input  logic [14*NUM_CLUSTERS-1:0]    clusters_in,
  input  logic                          cluster_strobe,
  output logic [16*NUM_VFATS-1:0]       vfat_words,
  output logic                          frame_sync,
  output logic [3:0]                    cluster_count,
  output logic                          strobe_err
);
  localparam int          NSTRIPS = 64 * NUM_VFATS;
  localparam logic [13:0] EMPTY   = 14'h07FF;

  logic [1:0]                     phase_q, phase_d;
  logic [NUM_CLUSTERS-1:0][13:0]  hold_q, hold_d;
  logic                           cap_q, cap_d;   // holding reg carries a real frame
  logic                           txv_q, txv_d;   // transmit map carries a real frame
  logic [NSTRIPS-1:0]             acc_q, acc_d, tx_q, tx_d, exp_mask;
  logic [3:0]                     cnt_tx_q, cnt_tx_d, count_q, count_d;
  logic [16*NUM_VFATS-1:0]        words_q, words_d, words_sel;
  logic                           sync_q, sync_d, serr_q, serr_d;

  // One edge after capture the phase is 1, so the pair / word slot lags the
  // phase by one: phase 1..3 -> slot 0..2, phase 0 -> slot 3 (handoff edge).
  logic [1:0]  slot;
  logic [13:0] c0, c1;
  assign slot = phase_q - 2'd1;
  assign c0   = hold_q[{slot, 1'b0}];
  assign c1   = hold_q[{slot, 1'b1}];

  // Strip s is covered by cluster c if c is valid and addr <= s <= addr+size.
  // Valid addresses end at NSTRIPS-1, so strips past the map never exist.
  function automatic logic strip_hit(input logic [13:0] c, input logic [11:0] s);
    logic [11:0] lo, hi;
    lo = {1'b0, c[10:0]};
    hi = lo + {9'd0, c[13:11]};
    return (lo < 12'(NSTRIPS)) && (s >= lo) && (s <= hi);
  endfunction

  function automatic logic [3:0] valid_count(input logic [NUM_CLUSTERS-1:0][13:0] h);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++)
      if ({1'b0, h[i][10:0]} < 12'(NSTRIPS)) n = n + 4'd1;
    return n;
  endfunction

  for (genvar s = 0; s < NSTRIPS; s++) begin : g_strip
    assign exp_mask[s] = strip_hit(c0, 12'(s)) | strip_hit(c1, 12'(s));
  end

  for (genvar v = 0; v < NUM_VFATS; v++) begin : g_vfat
    assign words_sel[16*v +: 16] = tx_q[64*v + 16*slot +: 16];
  end

  always_comb begin
    phase_d  = phase_q + 2'd1;
    hold_d   = hold_q;
    cap_d    = cap_q;
    txv_d    = txv_q;
    acc_d    = acc_q | exp_mask;
    tx_d     = tx_q;
    cnt_tx_d = cnt_tx_q;
    count_d  = count_q;
    serr_d   = cluster_strobe && (phase_q != 2'd0);
    words_d  = txv_q ? words_sel : '0;
    sync_d   = txv_q && (phase_q == 2'd1);
    if (phase_q == 2'd1) count_d = txv_q ? cnt_tx_q : 4'd0;
    if (phase_q == 2'd0) begin
      // Last pair lands straight in the transmit map; the accumulator is
      // emptied on this same edge so the next frame starts clean.
      tx_d     = acc_q | exp_mask;
      acc_d    = '0;
      cnt_tx_d = valid_count(hold_q);
      txv_d    = cap_q;
      cap_d    = 1'b1;
      hold_d   = cluster_strobe ? clusters_in : {NUM_CLUSTERS{EMPTY}};
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      hold_q   <= '0;
      cap_q    <= 1'b0;
      txv_q    <= 1'b0;
      acc_q    <= '0;
      tx_q     <= '0;
      cnt_tx_q <= '0;
      count_q  <= '0;
      words_q  <= '0;
      sync_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      cap_q    <= cap_d;
      txv_q    <= txv_d;
      acc_q    <= acc_d;
      tx_q     <= tx_d;
      cnt_tx_q <= cnt_tx_d;
      count_q  <= count_d;
      words_q  <= words_d;
      sync_q   <= sync_d;
      serr_q   <= serr_d;
    end
  end

  assign vfat_words    = words_q;
  assign frame_sync    = sync_q;
  assign cluster_count = count_q;
  assign strobe_err    = serr_q;
endmodule

// File: tb/tb_cluster_unpacker.sv
module tb_cluster_unpacker;
  localparam logic [13:0] E = 14'h07FF;

  logic         clock4x = 1'b0;
  logic         reset_n = 1'b1;
  logic [111:0] clusters_in;
  logic         cluster_strobe;
  logic [383:0] vfat_words;
  logic         frame_sync;
  logic [3:0]   cluster_count;
  logic         strobe_err;

  always #5 clock4x = ~clock4x;

  cluster_unpacker #(.NUM_VFATS(24), .NUM_CLUSTERS(8)) dut (
    .clock4x(clock4x), .reset_n(reset_n), .clusters_in(clusters_in),
    .cluster_strobe(cluster_strobe), .vfat_words(vfat_words),
    .frame_sync(frame_sync), .cluster_count(cluster_count), .strobe_err(strobe_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [383:0] got, input logic [383:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frames are captured on every 4th edge after reset release (edge 0, 4, ...);
  // frame f is shown on edges 4f+5 .. 4f+8, word k on edge 4f+5+k.
  int             ecount   = 0;   // edges seen since release = index of next edge
  logic [1535:0]  fmap [8];
  logic [3:0]     fcnt [8];
  logic           serr_exp = 1'b0;

  function automatic logic [1535:0] model_map(input logic [111:0] cl, input logic stb);
    logic [1535:0] m;
    m = '0;
    if (stb)
      for (int i = 0; i < 8; i++) begin
        int a, z;
        a = int'(cl[14*i +: 11]);
        z = int'(cl[14*i+11 +: 3]);
        if (a < 1536)
          for (int s = a; s <= a + z && s < 1536; s++) m[s] = 1'b1;
      end
    return m;
  endfunction

  function automatic logic [3:0] model_cnt(input logic [111:0] cl, input logic stb);
    logic [3:0] n;
    n = '0;
    if (stb)
      for (int i = 0; i < 8; i++)
        if (int'(cl[14*i +: 11]) < 1536) n++;
    return n;
  endfunction

  always @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      ecount   <= 0;
      serr_exp <= 1'b0;
    end else begin
      if (ecount % 4 == 0) begin
        fmap[(ecount / 4) % 8] <= model_map(clusters_in, cluster_strobe);
        fcnt[(ecount / 4) % 8] <= model_cnt(clusters_in, cluster_strobe);
      end
      serr_exp <= cluster_strobe && (ecount % 4 != 0);
      ecount   <= ecount + 1;
    end
  end

  always @(negedge clock4x) begin
    logic [383:0] ew;
    logic         es, ee;
    logic [3:0]   ec;
    int           e, f, k;
    ew = '0; es = 1'b0; ec = '0; ee = 1'b0;
    if (reset_n) begin
      ee = serr_exp;
      if (ecount >= 6) begin
        e = ecount - 1;
        f = (e - 5) / 4;
        k = (e - 5) % 4;
        for (int v = 0; v < 24; v++) ew[16*v +: 16] = fmap[f % 8][64*v + 16*k +: 16];
        es = (k == 0);
        ec = fcnt[f % 8];
      end
    end
    check("cyc_words", vfat_words, ew);
    check("cyc_sync", 384'(frame_sync), 384'(es));
    check("cyc_count", 384'(cluster_count), 384'(ec));
    check("cyc_serr", 384'(strobe_err), 384'(ee));
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [13:0] mk(input int a, input int z);
    return {3'(z), 11'(a)};
  endfunction

  task automatic wait_phase(input int p);
    while (ecount % 4 != p) @(negedge clock4x);
  endtask

  // Capture cl at the next phase-0 edge, return at the negedge holding word 0.
  task automatic send(input logic [111:0] cl);
    wait_phase(0);
    clusters_in = cl; cluster_strobe = 1'b1;
    @(negedge clock4x);
    cluster_strobe = 1'b0;
    repeat (5) @(negedge clock4x);
  endtask

  logic [111:0] cl;
  int           strips [3] = '{5, 100, 1000};

  initial begin
    clusters_in = {8{E}}; cluster_strobe = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock4x);
    check("rst_words", vfat_words, '0);
    check("rst_misc", 384'({frame_sync, cluster_count, strobe_err}), '0);
    reset_n = 1'b1;

    // single strip 0
    cl = {8{E}}; cl[13:0] = mk(0, 0);
    send(cl);
    check("t1_v0w0", 384'(vfat_words[15:0]), 384'(16'h0001));
    check("t1_rest", 384'(vfat_words[383:16]), '0);
    check("t1_sync", 384'(frame_sync), 384'(1'b1));
    check("t1_count", 384'(cluster_count), 384'(4'd1));

    // cross-VFAT span 60..67
    cl = {8{E}}; cl[13:0] = mk(60, 7);
    send(cl);
    check("t2_v1w0", 384'(vfat_words[31:16]), 384'(16'h000F));
    repeat (3) @(negedge clock4x);
    check("t2_v0w3", 384'(vfat_words[15:0]), 384'(16'hF000));

    // top-end clip, no wrap
    cl = {8{E}}; cl[13:0] = mk(1533, 7);
    send(cl);
    check("t3_v0w0", 384'(vfat_words[15:0]), '0);
    repeat (3) @(negedge clock4x);
    check("t3_v23w3", 384'(vfat_words[383:368]), 384'(16'hE000));

    // mixed valid / invalid with duplicate
    cl = {E, mk(300, 2), E, mk(20, 1), mk(1600, 0), mk(10, 0), mk(2047, 7), mk(10, 0)};
    send(cl);
    check("t4_count", 384'(cluster_count), 384'(4'd4));
    check("t4_v0w0", 384'(vfat_words[15:0]), 384'(16'h0400));
    @(negedge clock4x);
    check("t4_v0w1", 384'(vfat_words[15:0]), 384'(16'h0030));
    @(negedge clock4x);
    check("t4_v4w2", 384'(vfat_words[79:64]), 384'(16'h7000));

    // back-to-back frames, strips 5 / 100 / 1000
    wait_phase(0);
    for (int i = 0; i < 3; i++) begin
      cl = {8{E}}; cl[13:0] = mk(strips[i], 0);
      clusters_in = cl; cluster_strobe = 1'b1;
      @(negedge clock4x);
      cluster_strobe = 1'b0;
      repeat (3) @(negedge clock4x);
    end
    check("t5_strip100", 384'(vfat_words[31:16]), 384'(16'h0010));
    repeat (4) @(negedge clock4x);
    check("t5_strip1000", 384'(vfat_words[255:240]), 384'(16'h0100));

    // strobe in phase 2
    wait_phase(2);
    cl = {8{E}}; cl[13:0] = mk(7, 0);
    clusters_in = cl; cluster_strobe = 1'b1;
    @(negedge clock4x);
    cluster_strobe = 1'b0;
    check("t6_serr_hi", 384'(strobe_err), 384'(1'b1));
    @(negedge clock4x);
    check("t6_serr_lo", 384'(strobe_err), '0);
    repeat (6) @(negedge clock4x);
    check("t6_sync", 384'(frame_sync), 384'(1'b1));
    check("t6_words", vfat_words, '0);
    check("t6_count", 384'(cluster_count), '0);

    // reset mid-frame
    wait_phase(0);
    cl = {8{E}}; cl[13:0] = mk(200, 3);
    clusters_in = cl; cluster_strobe = 1'b1;
    @(negedge clock4x);
    cluster_strobe = 1'b0;
    repeat (2) @(negedge clock4x);
    @(posedge clock4x);
    #1 reset_n = 1'b0;
    @(negedge clock4x);
    check("t7_rst_words", vfat_words, '0);
    check("t7_rst_misc", 384'({frame_sync, cluster_count}), '0);
    repeat (2) @(negedge clock4x);
    reset_n = 1'b1;
    cl = {8{E}}; cl[13:0] = mk(5, 0);
    send(cl);
    check("t7_v0w0", 384'(vfat_words[15:0]), 384'(16'h0020));
    check("t7_count", 384'(cluster_count), 384'(4'd1));
    check("t7_sync", 384'(frame_sync), 384'(1'b1));

    repeat (8) @(negedge clock4x);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
